// File: rtl/bcd_display_scanner.sv
// Six-digit multiplexed 7-segment driver for the HH:MM:SS clock.
// Time-multiplexes the BCD digits onto a shared active-low segment bus,
// with a dead time at the start of every digit slot, a 16-level PWM on-window,
// a per-frame snapshot of the digits, leading-zero blanking of the hour tens
// digit and a colon that blinks at 1 Hz.
// Every output is registered and reflects the counter state before the clock edge.
module bcd_display_scanner #(
   parameter int unsigned DIGIT_CYCLES = 1000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] hh_tens,
   input  logic [3:0] hh_ones,
   input  logic [3:0] mm_tens,
   input  logic [3:0] mm_ones,
   input  logic [3:0] ss_tens,
   input  logic [3:0] ss_ones,
   input  logic [3:0] brightness,
   input  logic       blank_lz,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [5:0] dig_n,
   output logic       frame_start
);

   localparam int unsigned SW          = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(DIGIT_CYCLES - 1);
   localparam logic [31:0] ON_SPAN     = 32'(DIGIT_CYCLES - BLANK_CYCLES);
   localparam logic [31:0] BLANK_START = 32'(BLANK_CYCLES);

   logic [SW-1:0] slot_cnt_r;
   logic [2:0]    digit_idx_r;
   logic [23:0]   shadow_r;
   logic [3:0]    bright_r;
   logic          en_d_r;

   logic          snap_rise_s;
   logic          last_slot_s;
   logic [23:0]   live_digits_s;
   logic [23:0]   shadow_view_s;
   logic [3:0]    bright_view_s;
   logic [3:0]    cur_digit_s;
   logic [31:0]   on_len_s;
   logic [31:0]   slot_ext_s;
   logic          in_window_s;
   logic [6:0]    next_seg_s;
   logic          next_dp_s;
   logic [5:0]    dig_sel_s;

   // BCD to active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign live_digits_s = {hh_tens, hh_ones, mm_tens, mm_ones, ss_tens, ss_ones};

   // The first scanning cycle sees the freshly sampled digits and brightness so the
   // very first slot after enable is already consistent with its own snapshot.
   always_comb begin
      snap_rise_s   = enable & ~en_d_r;
      last_slot_s   = (slot_cnt_r == SLOT_LAST);
      shadow_view_s = shadow_r;
      bright_view_s = bright_r;
      cur_digit_s   = 4'h0;
      next_seg_s    = 7'h7F;
      next_dp_s     = 1'b1;

      if (snap_rise_s) begin
         shadow_view_s = live_digits_s;
      end else begin
         shadow_view_s = shadow_r;
      end

      if (slot_cnt_r == {SW{1'b0}}) begin
         bright_view_s = brightness;
      end else begin
         bright_view_s = bright_r;
      end

      case (digit_idx_r)
         3'd0:    cur_digit_s = shadow_view_s[3:0];
         3'd1:    cur_digit_s = shadow_view_s[7:4];
         3'd2:    cur_digit_s = shadow_view_s[11:8];
         3'd3:    cur_digit_s = shadow_view_s[15:12];
         3'd4:    cur_digit_s = shadow_view_s[19:16];
         3'd5:    cur_digit_s = shadow_view_s[23:20];
         default: cur_digit_s = 4'h0;
      endcase

      if ((digit_idx_r == 3'd5) && blank_lz && (cur_digit_s == 4'd0)) begin
         next_seg_s = 7'h7F;
      end else begin
         next_seg_s = bcd_to_seg(cur_digit_s);
      end

      // Colon dots live on mm_ones and hh_ones and follow the seconds parity.
      if (((digit_idx_r == 3'd2) || (digit_idx_r == 3'd4)) && !shadow_view_s[0]) begin
         next_dp_s = 1'b0;
      end else begin
         next_dp_s = 1'b1;
      end
   end

   assign slot_ext_s  = 32'(slot_cnt_r);
   assign on_len_s    = (ON_SPAN * ({28'd0, bright_view_s} + 32'd1)) >> 4;
   assign in_window_s = (slot_ext_s >= BLANK_START) && (slot_ext_s < (BLANK_START + on_len_s));
   assign dig_sel_s   = ~(6'b000001 << digit_idx_r);

   // Slot/digit counters, frame snapshot and per-slot brightness latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_cnt_r  <= {SW{1'b0}};
         digit_idx_r <= 3'd0;
         shadow_r    <= 24'h000000;
         bright_r    <= 4'h0;
         en_d_r      <= 1'b0;
      end else if (!enable) begin
         slot_cnt_r  <= {SW{1'b0}};
         digit_idx_r <= 3'd0;
         en_d_r      <= 1'b0;
      end else begin
         en_d_r <= 1'b1;
         if (snap_rise_s || (last_slot_s && (digit_idx_r == 3'd5))) begin
            shadow_r <= live_digits_s;
         end else begin
            shadow_r <= shadow_r;
         end
         if (slot_cnt_r == {SW{1'b0}}) begin
            bright_r <= brightness;
         end else begin
            bright_r <= bright_r;
         end
         if (last_slot_s) begin
            slot_cnt_r <= {SW{1'b0}};
            if (digit_idx_r == 3'd5) begin
               digit_idx_r <= 3'd0;
            end else begin
               digit_idx_r <= digit_idx_r + 3'd1;
            end
         end else begin
            slot_cnt_r <= slot_cnt_r + {{(SW-1){1'b0}}, 1'b1};
         end
      end
   end

   // Registered display outputs; segments change only at slot start, inside the dead time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_n       <= 7'h7F;
         dp_n        <= 1'b1;
         dig_n       <= 6'h3F;
         frame_start <= 1'b0;
      end else if (!enable) begin
         seg_n       <= 7'h7F;
         dp_n        <= 1'b1;
         dig_n       <= 6'h3F;
         frame_start <= 1'b0;
      end else begin
         if (slot_cnt_r == {SW{1'b0}}) begin
            seg_n <= next_seg_s;
            dp_n  <= next_dp_s;
         end else begin
            seg_n <= seg_n;
            dp_n  <= dp_n;
         end
         if (in_window_s) begin
            dig_n <= dig_sel_s;
         end else begin
            dig_n <= 6'h3F;
         end
         frame_start <= (slot_cnt_r == {SW{1'b0}}) && (digit_idx_r == 3'd0);
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner with DIGIT_CYCLES=32, BLANK_CYCLES=4.
// The reference model works on the absolute edge index since scanning started:
// slot = n % 32, digit = (n / 32) % 6, frame = n / 192, with one snapshot per frame.
module tb_bcd_display_scanner;

   localparam int DC = 32;
   localparam int BC = 4;
   localparam int FRAME = 6 * DC;

   logic       clk = 1'b0;
   logic       reset, enable, blank_lz;
   logic [3:0] hh_tens, hh_ones, mm_tens, mm_ones, ss_tens, ss_ones, brightness;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [5:0] dig_n;
   logic       frame_start;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int         m_n;
   bit         m_run;
   logic [23:0] m_frame;
   logic [3:0] m_bright;
   logic [6:0] e_seg;
   logic       e_dp;
   logic [5:0] e_dig;
   logic       e_fs;
   logic [6:0] seg_tab [10];

   bcd_display_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .hh_tens(hh_tens), .hh_ones(hh_ones), .mm_tens(mm_tens), .mm_ones(mm_ones),
      .ss_tens(ss_tens), .ss_ones(ss_ones), .brightness(brightness), .blank_lz(blank_lz),
      .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] live_digits();
      return {hh_tens, hh_ones, mm_tens, mm_ones, ss_tens, ss_ones};
   endfunction

   task automatic set_time(input int h, input int m, input int s);
      hh_tens = 4'(h / 10); hh_ones = 4'(h % 10);
      mm_tens = 4'(m / 10); mm_ones = 4'(m % 10);
      ss_tens = 4'(s / 10); ss_ones = 4'(s % 10);
   endtask

   task automatic model_reset();
      m_run = 0; m_n = 0; m_frame = 24'h0; m_bright = 4'h0;
      e_seg = 7'h7F; e_dp = 1'b1; e_dig = 6'h3F; e_fs = 1'b0;
   endtask

   task automatic model_edge();
      int s, d, on;
      logic [3:0] v;
      logic [5:0] sel;
      if (!enable) begin
         m_run = 0; m_n = 0;
         e_seg = 7'h7F; e_dp = 1'b1; e_dig = 6'h3F; e_fs = 1'b0;
         return;
      end
      if (!m_run) begin
         m_run = 1; m_n = 0; m_frame = live_digits();
      end
      s = m_n % DC;
      d = (m_n / DC) % 6;
      if (s == 0) begin
         m_bright = brightness;
         v = m_frame[d*4 +: 4];
         if (d == 5 && blank_lz && v == 4'd0) e_seg = 7'h7F;
         else if (v > 4'd9) e_seg = 7'h3F;
         else e_seg = seg_tab[v];
         e_dp = !((d == 2 || d == 4) && m_frame[0] == 1'b0);
      end
      on = ((DC - BC) * (int'(m_bright) + 1)) / 16;
      sel = 6'b111111;
      sel[d] = 1'b0;
      e_dig = (s >= BC && s < BC + on) ? sel : 6'h3F;
      e_fs = ((m_n % FRAME) == 0);
      if ((m_n % FRAME) == FRAME - 1) m_frame = live_digits();
      m_n++;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; blank_lz = 1'b0; brightness = 4'h0;
      set_time(0, 0, 0);
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({seg_n, dp_n, dig_n, frame_start} !== {7'h7F, 1'b1, 6'h3F, 1'b0}) begin
            miscompares++;
            $display("FAIL reset got %h want %h", {seg_n, dp_n, dig_n, frame_start}, {7'h7F, 1'b1, 6'h3F, 1'b0});
         end
      end
   endtask

   task automatic test_timing();
      int low0, fs_cnt, last_fs;
      low0 = 0; fs_cnt = 0; last_fs = -1;
      set_time(12, 34, 56); brightness = 4'd15; blank_lz = 1'b0;
      enable = 1'b1; reset = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         vectors++;
         if ({seg_n, dp_n, dig_n, frame_start} !== {e_seg, e_dp, e_dig, e_fs}) begin
            miscompares++;
            $display("FAIL timing n=%0d got %h want %h", m_n - 1, {seg_n, dp_n, dig_n, frame_start}, {e_seg, e_dp, e_dig, e_fs});
         end
         if (!dig_n[0]) begin
            low0++;
            vectors++;
            if (seg_n !== 7'h02) begin
               miscompares++; $display("FAIL timing_slot0_seg got %h want 02", seg_n);
            end
         end
         if (!dig_n[5]) begin
            vectors++;
            if (seg_n !== 7'h79) begin
               miscompares++; $display("FAIL timing_slot5_seg got %h want 79", seg_n);
            end
         end
         if (frame_start) begin
            if (last_fs >= 0) begin
               vectors++;
               if (i - last_fs != FRAME) begin
                  miscompares++; $display("FAIL frame_period got %0d want %0d", i - last_fs, FRAME);
               end
            end
            last_fs = i;
            fs_cnt++;
         end
      end
      vectors++;
      if (low0 != 56) begin
         miscompares++; $display("FAIL timing_dig0_low got %0d want 56", low0);
      end
      vectors++;
      if (fs_cnt != 2) begin
         miscompares++; $display("FAIL timing_frame_start got %0d want 2", fs_cnt);
      end
   endtask

   task automatic test_pwm();
      int lows;
      while (m_n % DC != 0) tick();
      brightness = 4'd7;
      for (int k = 0; k < 2; k++) begin
         lows = 0;
         for (int i = 0; i < DC; i++) begin
            tick();
            vectors++;
            if ({seg_n, dp_n, dig_n, frame_start} !== {e_seg, e_dp, e_dig, e_fs}) begin
               miscompares++;
               $display("FAIL pwm n=%0d got %h want %h", m_n - 1, {seg_n, dp_n, dig_n, frame_start}, {e_seg, e_dp, e_dig, e_fs});
            end
            if (dig_n != 6'h3F) lows++;
            if (i == DC / 2) brightness = 4'd0;
         end
         vectors++;
         if (lows != ((k == 0) ? 14 : 1)) begin
            miscompares++; $display("FAIL pwm_on_len slot%0d got %0d want %0d", k, lows, (k == 0) ? 14 : 1);
         end
      end
   endtask

   task automatic test_tear_free();
      brightness = 4'd15; blank_lz = 1'b0;
      set_time(9, 59, 59);
      while (m_n % FRAME != 0) tick();
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         vectors++;
         if ({seg_n, dp_n, dig_n, frame_start} !== {e_seg, e_dp, e_dig, e_fs}) begin
            miscompares++;
            $display("FAIL tear n=%0d got %h want %h", m_n - 1, {seg_n, dp_n, dig_n, frame_start}, {e_seg, e_dp, e_dig, e_fs});
         end
         if (!dig_n[5]) begin
            vectors++;
            if (seg_n !== ((i < FRAME) ? 7'h40 : 7'h79)) begin
               miscompares++; $display("FAIL tear_hh_tens i=%0d got %h", i, seg_n);
            end
         end
         if (i == 3 * DC + 10) set_time(10, 0, 0);
      end
   endtask

   task automatic test_blank_colon_random();
      for (int f = 0; f < 10; f++) begin
         case (f)
            0: begin set_time(3, 44, 24); mm_ones = 4'hC; hh_tens = 4'd0; blank_lz = 1'b1; end
            1: begin set_time(5, 12, 35); blank_lz = 1'b0; end
            default: begin
               {hh_tens, hh_ones, mm_tens, mm_ones} = 16'($urandom);
               {ss_tens, ss_ones} = 8'($urandom);
               if ($urandom_range(0, 1) == 0) hh_tens = 4'd0;
               blank_lz = 1'($urandom);
            end
         endcase
         brightness = 4'($urandom);
         for (int i = 0; i < FRAME; i++) begin
            tick();
            vectors++;
            if ({seg_n, dp_n, dig_n, frame_start} !== {e_seg, e_dp, e_dig, e_fs}) begin
               miscompares++;
               $display("FAIL random f=%0d n=%0d got %h want %h", f, m_n - 1, {seg_n, dp_n, dig_n, frame_start}, {e_seg, e_dp, e_dig, e_fs});
            end
            if (f > 1 && $urandom_range(0, 40) == 0) begin
               brightness = 4'($urandom);
               {ss_tens, ss_ones} = 8'($urandom);
               blank_lz = 1'($urandom);
            end
         end
      end
   endtask

   task automatic test_enable();
      set_time(23, 58, 7); brightness = 4'd15; blank_lz = 1'b1;
      while (!(((m_n / DC) % 6) == 3 && (m_n % DC) == 12)) tick();
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({seg_n, dp_n, dig_n, frame_start} !== {7'h7F, 1'b1, 6'h3F, 1'b0}) begin
            miscompares++; $display("FAIL enable_dark got %h", {seg_n, dp_n, dig_n, frame_start});
         end
      end
      set_time(1, 2, 4);
      enable = 1'b1;
      tick();
      vectors++;
      if (frame_start !== 1'b1) begin
         miscompares++; $display("FAIL enable_restart_fs got %b want 1", frame_start);
      end
      for (int i = 1; i < FRAME + 8; i++) begin
         tick();
         vectors++;
         if ({seg_n, dp_n, dig_n, frame_start} !== {e_seg, e_dp, e_dig, e_fs}) begin
            miscompares++;
            $display("FAIL enable_resume n=%0d got %h want %h", m_n - 1, {seg_n, dp_n, dig_n, frame_start}, {e_seg, e_dp, e_dig, e_fs});
         end
      end
   endtask

   task automatic test_async_reset();
      int budget;
      budget = 0;
      brightness = 4'd15;
      while (dig_n == 6'h3F && budget < 200) begin
         tick();
         budget++;
      end
      vectors++;
      if (dig_n == 6'h3F) begin
         miscompares++; $display("FAIL async_reset_setup got dig_n %b want a lit digit", dig_n);
      end
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if ({seg_n, dp_n, dig_n, frame_start} !== {7'h7F, 1'b1, 6'h3F, 1'b0}) begin
         miscompares++; $display("FAIL async_reset got %h want %h", {seg_n, dp_n, dig_n, frame_start}, {7'h7F, 1'b1, 6'h3F, 1'b0});
      end
      model_reset();
      tick();
      reset = 1'b0;
      set_time(20, 40, 11);
      for (int i = 0; i < FRAME; i++) begin
         tick();
         vectors++;
         if ({seg_n, dp_n, dig_n, frame_start} !== {e_seg, e_dp, e_dig, e_fs}) begin
            miscompares++;
            $display("FAIL after_reset n=%0d got %h want %h", m_n - 1, {seg_n, dp_n, dig_n, frame_start}, {e_seg, e_dp, e_dig, e_fs});
         end
      end
   endtask

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      test_reset();
      test_timing();
      test_pwm();
      test_tear_free();
      test_blank_colon_random();
      test_enable();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
